// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the MPS multi-port register file.
// Holds the clear-engine state encoding, default geometry and a clog2 helper.
// Optional feature macro used by the design: MPS_REGFILE_BYPASS_EN.
package mps_regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_NUM_RD = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Smallest r such that 2**r >= v (returns 0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the decode/writeback stages (master) and the register file (slave).
// Signals: two write ports, packed read addresses/data/pending, pending-set request,
// bulk-clear request and clear busy status.
interface regfile_mp_if
  import mps_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NUM_RD = DEF_NUM_RD
) ();

  localparam int unsigned ADDR_W = clog2(DEPTH);

  logic                       wr0_en;
  logic [ADDR_W-1:0]          wr0_addr;
  logic [DATA_W-1:0]          wr0_data;
  logic                       wr1_en;
  logic [ADDR_W-1:0]          wr1_addr;
  logic [DATA_W-1:0]          wr1_data;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_pending;
  logic                       pend_set_en;
  logic [ADDR_W-1:0]          pend_set_addr;
  logic                       clear_req;
  logic                       clear_busy;

  modport master (
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output rd_addr, pend_set_en, pend_set_addr, clear_req,
    input  rd_data, rd_pending, clear_busy
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  rd_addr, pend_set_en, pend_set_addr, clear_req,
    output rd_data, rd_pending, clear_busy
  );

endinterface

// File: rtl/regfile_mp_clear_fsm.sv
// Sequential bulk-clear engine: sweeps every entry once, one per cycle.
// Ports: clock, nreset (sync, active-low), clear_req (pulse or level),
// clear_busy (high for exactly DEPTH cycles), clr_en/clr_addr (entry to zero this cycle).
module regfile_clear_fsm
  import mps_regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state;
  clr_state_e        state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  // State and sweep counter registers.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: exit happens on the last entry, so the counter never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    clear_busy = 1'b0;
    clr_en     = 1'b0;
    clr_addr   = cnt;
    if (state == ST_CLEAR) begin
      clear_busy = 1'b1;
      clr_en     = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with per-entry pending (scoreboard) bits
// and a sequential bulk-clear engine.
// Ports: clock, nreset (sync, active-low), bus (regfile_mp_if.slave) carrying
// two write ports, NUM_RD combinational read ports with pending bits, pend_set,
// clear_req and clear_busy.
// Optional feature: define MPS_REGFILE_BYPASS_EN to forward same-cycle write
// data (and pending) onto matching read ports.
module regfile_mp
  import mps_regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input logic         clock,
  input logic         nreset,
  regfile_mp_if.slave bus
);

  localparam int unsigned ADDR_W = clog2(DEPTH);

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         pending;
  logic [DEPTH-1:0]         pend_nxt;

  logic                     clr_en;
  logic [ADDR_W-1:0]        clr_addr;

  logic                     wr0_eff;
  logic                     wr1_eff;
  logic                     pset_eff;

  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_pend_c;
  logic [ADDR_W-1:0]        ra;
  logic [DATA_W-1:0]        rd;
  logic                     rp;

  regfile_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clock      (clock),
    .nreset     (nreset),
    .clear_req  (bus.clear_req),
    .clear_busy (bus.clear_busy),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr)
  );

  // Qualified requests: dropped while clearing or when targeting the zero register;
  // wr0 also yields to wr1 on the same address.
  always_comb begin
    wr0_eff  = bus.wr0_en && !clr_en
               && !((ZERO_REG != 0) && (bus.wr0_addr == '0))
               && !(bus.wr1_en && (bus.wr1_addr == bus.wr0_addr));
    wr1_eff  = bus.wr1_en && !clr_en
               && !((ZERO_REG != 0) && (bus.wr1_addr == '0));
    pset_eff = bus.pend_set_en && !clr_en
               && !((ZERO_REG != 0) && (bus.pend_set_addr == '0));
  end

  // Pending update: writes clear, pend_set applied last so a newer producer wins.
  always_comb begin
    pend_nxt = pending;
    if (wr0_eff)  pend_nxt[bus.wr0_addr]      = 1'b0;
    if (wr1_eff)  pend_nxt[bus.wr1_addr]      = 1'b0;
    if (pset_eff) pend_nxt[bus.pend_set_addr] = 1'b1;
  end

  // Storage: reset, clear sweep, or normal writes.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else if (clr_en) begin
      regs[clr_addr]    <= '0;
      pending[clr_addr] <= 1'b0;
    end else begin
      if (wr0_eff) regs[bus.wr0_addr] <= bus.wr0_data;
      if (wr1_eff) regs[bus.wr1_addr] <= bus.wr1_data;
      pending <= pend_nxt;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd_data_c = '0;
    rd_pend_c = '0;
    ra        = '0;
    rd        = '0;
    rp        = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rd = regs[ra];
      rp = pending[ra];
`ifdef MPS_REGFILE_BYPASS_EN
      // Forwarded hit is no longer pending unless re-marked this same cycle.
      if (wr1_eff && (bus.wr1_addr == ra)) begin
        rd = bus.wr1_data;
        rp = pset_eff && (bus.pend_set_addr == ra);
      end else if (wr0_eff && (bus.wr0_addr == ra)) begin
        rd = bus.wr0_data;
        rp = pset_eff && (bus.pend_set_addr == ra);
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
        rp = 1'b0;
      end
      rd_data_c[k*DATA_W +: DATA_W] = rd;
      rd_pend_c[k]                  = rp;
    end
  end

  assign bus.rd_data    = rd_data_c;
  assign bus.rd_pending = rd_pend_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (DATA_W=32, DEPTH=16, NUM_RD=2, ZERO_REG=1).
module tb_regfile_mp;
  import mps_regfile_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NRD   = 2;
  localparam int AW    = 4;

  logic clock;
  logic nreset;

  regfile_mp_if #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD)) bus ();

  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .ZERO_REG(1)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_busy;
  int            m_cnt;

  int total;
  int bad;

  // Apply one clock edge worth of architectural rules to the model.
  task automatic model_step();
    int a0, a1, ps;
    a0 = int'(bus.wr0_addr);
    a1 = int'(bus.wr1_addr);
    ps = int'(bus.pend_set_addr);
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      m_regs[m_cnt] = '0;
      m_pend[m_cnt] = 1'b0;
      if (m_cnt == DEPTH - 1) m_busy = 1'b0;
      else m_cnt++;
    end else begin
      if (bus.wr0_en && a0 != 0 && !(bus.wr1_en && a1 == a0)) begin
        m_regs[a0] = bus.wr0_data;
        m_pend[a0] = 1'b0;
      end
      if (bus.wr1_en && a1 != 0) begin
        m_regs[a1] = bus.wr1_data;
        m_pend[a1] = 1'b0;
      end
      if (bus.pend_set_en && ps != 0) m_pend[ps] = 1'b1;
      if (bus.clear_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int k);
    logic [AW-1:0] av;
    av = bus.rd_addr[k*AW +: AW];
    if (av == '0) return '0;
`ifdef MPS_REGFILE_BYPASS_EN
    if (nreset && !m_busy) begin
      if (bus.wr1_en && bus.wr1_addr == av) return bus.wr1_data;
      if (bus.wr0_en && bus.wr0_addr == av) return bus.wr0_data;
    end
`endif
    return m_regs[int'(av)];
  endfunction

  function automatic logic exp_pend(input int k);
    logic [AW-1:0] av;
    av = bus.rd_addr[k*AW +: AW];
    if (av == '0) return 1'b0;
`ifdef MPS_REGFILE_BYPASS_EN
    if (nreset && !m_busy &&
        ((bus.wr1_en && bus.wr1_addr == av) || (bus.wr0_en && bus.wr0_addr == av)))
      return bus.pend_set_en && (bus.pend_set_addr == av);
`endif
    return m_pend[int'(av)];
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr0_en        = 1'b0;
    bus.wr0_addr      = '0;
    bus.wr0_data      = '0;
    bus.wr1_en        = 1'b0;
    bus.wr1_addr      = '0;
    bus.wr1_data      = '0;
    bus.pend_set_en   = 1'b0;
    bus.pend_set_addr = '0;
    bus.clear_req     = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic fill_random(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.wr0_en   = 1'b1;
      bus.wr0_addr = AW'(i);
      bus.wr0_data = $urandom | 32'h1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    fill_random(1, 15);
    bus.pend_set_en   = 1'b1;
    bus.pend_set_addr = AW'(6);
    tick();
    idle_inputs();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    total++;
    if (bus.clear_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=0", bus.clear_busy);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(a, a + 1);
      #1;
      for (int k = 0; k < NRD; k++) begin
        total++;
        if (bus.rd_data[k*DW +: DW] !== 32'h0 || bus.rd_pending[k] !== 1'b0) begin
          bad++;
          $display("FAIL reset_read addr=%0d got=%h/%b exp=0/0", a + k,
                   bus.rd_data[k*DW +: DW], bus.rd_pending[k]);
        end
      end
    end
  endtask

  task automatic test_dual_write();
    bus.wr0_en = 1'b1; bus.wr0_addr = AW'(3); bus.wr0_data = 32'hAAAA;
    bus.wr1_en = 1'b1; bus.wr1_addr = AW'(3); bus.wr1_data = 32'h5555;
    set_rd(3, 2);
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.rd_data[0 +: DW] !== 32'h5555) begin
      bad++;
      $display("FAIL dual_write got=%h exp=%h", bus.rd_data[0 +: DW], 32'h5555);
    end
    total++;
    if (bus.rd_data[DW +: DW] !== exp_data(1)) begin
      bad++;
      $display("FAIL dual_write_other got=%h exp=%h", bus.rd_data[DW +: DW], exp_data(1));
    end
  endtask

  task automatic test_zero_reg();
    bus.wr0_en = 1'b1; bus.wr0_addr = '0; bus.wr0_data = 32'hFFFF_FFFF;
    bus.pend_set_en = 1'b1; bus.pend_set_addr = '0;
    set_rd(0, 0);
    #1;
    total++;
    if (bus.rd_data[0 +: DW] !== 32'h0 || bus.rd_pending[0] !== 1'b0) begin
      bad++;
      $display("FAIL zero_same_cycle got=%h/%b exp=0/0", bus.rd_data[0 +: DW], bus.rd_pending[0]);
    end
    tick();
    idle_inputs();
    #1;
    for (int k = 0; k < NRD; k++) begin
      total++;
      if (bus.rd_data[k*DW +: DW] !== 32'h0 || bus.rd_pending[k] !== 1'b0) begin
        bad++;
        $display("FAIL zero_reg port%0d got=%h/%b exp=0/0", k,
                 bus.rd_data[k*DW +: DW], bus.rd_pending[k]);
      end
    end
  endtask

  task automatic test_scoreboard();
    set_rd(5, 4);
    bus.pend_set_en = 1'b1; bus.pend_set_addr = AW'(5);
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.rd_pending[0] !== 1'b1) begin
      bad++;
      $display("FAIL sb_set got=%b exp=1", bus.rd_pending[0]);
    end
    bus.wr1_en = 1'b1; bus.wr1_addr = AW'(5); bus.wr1_data = $urandom;
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.rd_pending[0] !== 1'b0) begin
      bad++;
      $display("FAIL sb_clear got=%b exp=0", bus.rd_pending[0]);
    end
    bus.pend_set_en = 1'b1; bus.pend_set_addr = AW'(5);
    bus.wr0_en = 1'b1; bus.wr0_addr = AW'(5); bus.wr0_data = $urandom;
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.rd_pending[0] !== 1'b1) begin
      bad++;
      $display("FAIL sb_set_wins got=%b exp=1", bus.rd_pending[0]);
    end
    total++;
    if (bus.rd_pending[1] !== exp_pend(1)) begin
      bad++;
      $display("FAIL sb_neighbour got=%b exp=%b", bus.rd_pending[1], exp_pend(1));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.wr0_en        = 1'($urandom_range(0, 1));
      bus.wr0_addr      = AW'($urandom_range(0, DEPTH - 1));
      bus.wr0_data      = $urandom;
      bus.wr1_en        = 1'($urandom_range(0, 1));
      bus.wr1_addr      = AW'($urandom_range(0, DEPTH - 1));
      bus.wr1_data      = $urandom;
      bus.pend_set_en   = 1'($urandom_range(0, 1));
      bus.pend_set_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.clear_req     = ($urandom_range(0, 59) == 0);
      set_rd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      #1;
      for (int k = 0; k < NRD; k++) begin
        total++;
        if (bus.rd_data[k*DW +: DW] !== exp_data(k) || bus.rd_pending[k] !== exp_pend(k)) begin
          bad++;
          $display("FAIL random n=%0d port%0d got=%h/%b exp=%h/%b", n, k,
                   bus.rd_data[k*DW +: DW], bus.rd_pending[k], exp_data(k), exp_pend(k));
        end
      end
      total++;
      if (bus.clear_busy !== m_busy) begin
        bad++;
        $display("FAIL random_busy n=%0d got=%b exp=%b", n, bus.clear_busy, m_busy);
      end
      tick();
    end
    idle_inputs();
    while (m_busy) tick();
  endtask

  task automatic test_bulk_clear();
    int n;
    fill_random(1, 15);
    bus.clear_req = 1'b1;
    tick();
    idle_inputs();
    n = 0;
    while (bus.clear_busy === 1'b1 && n < 40) begin
      if (n == 4) begin
        bus.wr0_en = 1'b1; bus.wr0_addr = AW'(9);  bus.wr0_data = 32'hDEAD_BEEF;
        bus.wr1_en = 1'b1; bus.wr1_addr = AW'(10); bus.wr1_data = 32'hCAFE_F00D;
        bus.pend_set_en = 1'b1; bus.pend_set_addr = AW'(11);
      end
      bus.clear_req = 1'b1;
      set_rd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      #1;
      for (int k = 0; k < NRD; k++) begin
        total++;
        if (bus.rd_data[k*DW +: DW] !== exp_data(k) || bus.rd_pending[k] !== exp_pend(k)) begin
          bad++;
          $display("FAIL clear_sweep n=%0d port%0d got=%h/%b exp=%h/%b", n, k,
                   bus.rd_data[k*DW +: DW], bus.rd_pending[k], exp_data(k), exp_pend(k));
        end
      end
      tick();
      idle_inputs();
      n++;
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL clear_duration got=%0d exp=16", n);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(a, a + 1);
      #1;
      for (int k = 0; k < NRD; k++) begin
        total++;
        if (bus.rd_data[k*DW +: DW] !== 32'h0 || bus.rd_pending[k] !== 1'b0) begin
          bad++;
          $display("FAIL clear_result addr=%0d got=%h/%b exp=0/0", a + k,
                   bus.rd_data[k*DW +: DW], bus.rd_pending[k]);
        end
      end
    end
  endtask

  task automatic test_clear_reset();
    fill_random(1, 15);
    bus.clear_req = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 7; i++) tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    total++;
    if (bus.clear_busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_reset_busy got=%b exp=0", bus.clear_busy);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(a, a + 1);
      #1;
      for (int k = 0; k < NRD; k++) begin
        total++;
        if (bus.rd_data[k*DW +: DW] !== 32'h0 || bus.rd_pending[k] !== 1'b0) begin
          bad++;
          $display("FAIL clear_reset_read addr=%0d got=%h/%b exp=0/0", a + k,
                   bus.rd_data[k*DW +: DW], bus.rd_pending[k]);
        end
      end
    end
    tick();
    total++;
    if (bus.clear_busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_reset_idle got=%b exp=0", bus.clear_busy);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    bus.wr0_en = 1'b1; bus.wr0_addr = AW'(7); bus.wr0_data = 32'hBEEF;
    tick();
    idle_inputs();
    bus.wr0_en = 1'b1; bus.wr0_addr = AW'(7); bus.wr0_data = 32'h1234;
    set_rd(0, 7);
    #1;
`ifdef MPS_REGFILE_BYPASS_EN
    want = 32'h1234;
`else
    want = 32'hBEEF;
`endif
    total++;
    if (bus.rd_data[DW +: DW] !== want) begin
      bad++;
      $display("FAIL bypass_same_cycle got=%h exp=%h", bus.rd_data[DW +: DW], want);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.rd_data[DW +: DW] !== 32'h1234) begin
      bad++;
      $display("FAIL bypass_next_cycle got=%h exp=%h", bus.rd_data[DW +: DW], 32'h1234);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_busy = 1'b0;
    m_cnt  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    nreset = 1'b0;
    idle_inputs();
    set_rd(0, 0);
    tick();
    nreset = 1'b1;
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_scoreboard();
    test_random();
    test_bulk_clear();
    test_clear_reset();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the next-generation MPS core. Adds the following over the current register file:
  - configurable width, depth and read-port count;
  - two write ports;
  - a per-register pending (scoreboard) bit;
  - a sequential bulk-clear engine.
- Sits between the decode stage (reads, pending set) and the writeback stage (writes, pending clear).

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 16, number of registers; power of two, >= 2.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 entry 0 reads as zero and ignores writes.
- ADDR_W, $clog2(DEPTH), derived; never overridden.

Ports:
- clock  in  1  rising-edge clock for all state.
- nreset  in  1  reset, synchronous, active-low.
- wr0_en  in  1  write port 0 enable.
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable.
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k is slice k.
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_pending  out  NUM_RD  pending bit of each read address.
- pend_set_en  in  1  mark a destination register as pending.
- pend_set_addr  in  ADDR_W  register to mark.
- clear_req  in  1  start a bulk clear (one-cycle pulse or level).
- clear_busy  out  1  high while the clear engine runs.

Behaviour:
- Reset, nreset=0 sampled at a rising edge:
  - all entries 0, all pending bits 0;
  - FSM to IDLE, clear counter 0, clear_busy=0;
  - rd_data reads 0 and rd_pending reads 0 from the following cycle.
- Reads are combinational from the stored array: rd_data[k] = regs[rd_addr[k]].
- Writes commit at the rising edge; write-to-read latency is 1 cycle unless bypass is enabled.
- When ZERO_REG=1:
  - writes to address 0 are dropped;
  - pend_set to address 0 is dropped;
  - rd_data for address 0 is 0 and rd_pending for address 0 is 0.
- Same-address dual write: wr1 wins and wr0 is discarded.
- Pending bits:
  - set by pend_set_en;
  - cleared by any enabled, non-dropped write to that address;
  - set and clear on the same address in the same cycle: set wins (a newer producer was issued).
- FSM IDLE:
  - clear_req=1 -> CLEAR, counter=0, clear_busy=1 on the next cycle.
- FSM CLEAR:
  - each cycle, entry[counter] <= 0 and pending[counter] <= 0, then counter++;
  - at counter=DEPTH-1: clear that entry, go to IDLE, clear_busy=0 on the next cycle;
  - total busy duration is exactly DEPTH cycles.
- During CLEAR:
  - wr0/wr1 and pend_set are ignored;
  - reads return current contents, which may be partially cleared;
  - clear_req is ignored, no restart.
- Counter wrap-around is impossible because the exit occurs at DEPTH-1.
- Reset asserted mid-CLEAR aborts the sweep: full reset state, IDLE.

Optional Feature:
- Macro MPS_REGFILE_BYPASS_EN.
- When defined, read ports forward same-cycle write data:
  - if wr1 hits rd_addr[k], rd_data[k] = wr1_data;
  - else if wr0 hits, rd_data[k] = wr0_data;
  - rd_pending[k] reads 0 for a forwarded hit unless pend_set hits the same address that cycle;
  - zero-register and CLEAR-state drop rules apply: dropped writes are not forwarded.
- When undefined: purely array reads with 1-cycle write visibility, and no forwarding logic is synthesised.

Decomposition:
- Shared package mps_regfile_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_CLEAR);
  - default DATA_W/DEPTH/NUM_RD constants;
  - a clog2 helper function.
- One natural sub-module, regfile_clear_fsm: owns the state, counter and clear_busy, and emits clr_en and clr_addr to the array.

Test Plan:
- Reset then read all: nreset=0 one cycle -> every rd_data=0, rd_pending=0, clear_busy=0.
- Dual write conflict: wr0 (addr 3, 0xAAAA) and wr1 (addr 3, 0x5555) same cycle -> next cycle rd_data[addr 3]=0x5555.
- Zero register: wr0 (addr 0, 0xFFFF_FFFF) plus pend_set addr 0 -> rd_data=0, rd_pending=0 for addr 0.
- Scoreboard:
  - pend_set addr 5 -> rd_pending=1 next cycle;
  - wr1 to addr 5 -> 0;
  - pend_set and wr0 both at addr 5 same cycle -> stays 1.
- Bulk clear, DEPTH=16, after filling with nonzero values:
  - pulse clear_req -> clear_busy high exactly 16 cycles;
  - a write issued at cycle 4 of CLEAR is ignored;
  - all entries 0 afterwards;
  - nreset at cycle 7 of a second clear -> IDLE, all 0.
- Bypass, with MPS_REGFILE_BYPASS_EN defined: wr0 (addr 7, 0x1234) while rd_addr[1]=7 -> rd_data[1]=0x1234 same cycle; without the macro it shows the old value.
